// File: rtl/wb_stage.sv
// Writeback stage: registers the execute result, formats load data, drives the
// register-file write port and bypasses operands. Optional retire counter: WB_INSTRET_EN.
module wb_stage #(
  parameter int REG_SIZE   = 32,
  parameter int NO_OF_REGS = 32,
  parameter int REGW       = $clog2(NO_OF_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ex_valid_i,
  input  logic                ex_reg_we_i,
  input  logic [REGW-1:0]     ex_rd_i,
  input  logic [1:0]          ex_wb_sel_i,
  input  logic [2:0]          ex_funct3_i,
  input  logic [REG_SIZE-1:0] ex_alu_res_i,
  input  logic [REG_SIZE-1:0] ex_pc_i,
  input  logic [REG_SIZE-1:0] ex_csr_rdata_i,
  input  logic [REG_SIZE-1:0] dmem_rdata_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [REGW-1:0]     raddr1_i,
  input  logic [REGW-1:0]     raddr2_i,
  input  logic [REG_SIZE-1:0] rdata1_rf_i,
  input  logic [REG_SIZE-1:0] rdata2_rf_i,
  output logic                we_o,
  output logic [REGW-1:0]     waddr_o,
  output logic [REG_SIZE-1:0] wdata_o,
  output logic [REG_SIZE-1:0] fwd_rdata1_o,
  output logic [REG_SIZE-1:0] fwd_rdata2_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]         instret_o
`endif
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_CSR  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic                r_valid;
  logic                r_reg_we;
  logic [REGW-1:0]     r_rd;
  wb_sel_e             r_wb_sel;
  logic [2:0]          r_funct3;
  logic [REG_SIZE-1:0] r_alu_res;
  logic [REG_SIZE-1:0] r_pc;
  logic [REG_SIZE-1:0] r_csr_rdata;

  logic [1:0]          w_off;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [REG_SIZE-1:0] w_load_data;
  logic [REG_SIZE-1:0] w_result;
  logic                w_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_reg_we    <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= WB_ALU;
      r_funct3    <= '0;
      r_alu_res   <= '0;
      r_pc        <= '0;
      r_csr_rdata <= '0;
    end else if (flush_i) begin
      // Only valid matters once killed; payload is left as-is.
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      r_valid     <= ex_valid_i;
      r_reg_we    <= ex_reg_we_i;
      r_rd        <= ex_rd_i;
      r_wb_sel    <= wb_sel_e'(ex_wb_sel_i);
      r_funct3    <= ex_funct3_i;
      r_alu_res   <= ex_alu_res_i;
      r_pc        <= ex_pc_i;
      r_csr_rdata <= ex_csr_rdata_i;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_off       = r_alu_res[1:0];
    w_byte      = dmem_rdata_i[{w_off, 3'b000} +: 8];
    w_half      = dmem_rdata_i[{w_off[1], 4'b0000} +: 16];
    w_load_data = dmem_rdata_i;
    unique case (r_funct3)
      F3_LB:   w_load_data = {{(REG_SIZE-8){w_byte[7]}}, w_byte};
      F3_LBU:  w_load_data = {{(REG_SIZE-8){1'b0}}, w_byte};
      F3_LH:   w_load_data = {{(REG_SIZE-16){w_half[15]}}, w_half};
      F3_LHU:  w_load_data = {{(REG_SIZE-16){1'b0}}, w_half};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    w_result = r_alu_res;
    unique case (r_wb_sel)
      WB_ALU:  w_result = r_alu_res;
      WB_LOAD: w_result = w_load_data;
      WB_PC4:  w_result = r_pc + REG_SIZE'(4);
      WB_CSR:  w_result = r_csr_rdata;
      default: w_result = r_alu_res;
    endcase
  end

  // x0 is hardwired to zero, so it is never written and never bypassed.
  assign w_we    = r_valid & r_reg_we & (r_rd != '0);
  assign we_o    = w_we;
  assign waddr_o = r_rd;
  assign wdata_o = w_result;

  assign fwd_rdata1_o = (w_we && (raddr1_i == r_rd)) ? w_result : rdata1_rf_i;
  assign fwd_rdata2_o = (w_we && (raddr2_i == r_rd)) ? w_result : rdata2_rf_i;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // An instruction retires when it leaves WB; a stalled one counts once on exit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instret <= '0;
    end else if (r_valid && !stall_i) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a behavioural model of the WB occupant and retire count.
module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i, ex_reg_we_i;
  logic [4:0]  ex_rd_i;
  logic [1:0]  ex_wb_sel_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_alu_res_i, ex_pc_i, ex_csr_rdata_i, dmem_rdata_i;
  logic        stall_i, flush_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_rf_i, rdata2_rf_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o, fwd_rdata1_o, fwd_rdata2_o;
`ifdef WB_INSTRET_EN
  logic [63:0] instret_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  wb_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_reg_we_i(ex_reg_we_i), .ex_rd_i(ex_rd_i),
    .ex_wb_sel_i(ex_wb_sel_i), .ex_funct3_i(ex_funct3_i),
    .ex_alu_res_i(ex_alu_res_i), .ex_pc_i(ex_pc_i), .ex_csr_rdata_i(ex_csr_rdata_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_i(stall_i), .flush_i(flush_i),
    .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
    .rdata1_rf_i(rdata1_rf_i), .rdata2_rf_i(rdata2_rf_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .fwd_rdata1_o(fwd_rdata1_o), .fwd_rdata2_o(fwd_rdata2_o)
`ifdef WB_INSTRET_EN
    , .instret_o(instret_o)
`endif
  );

  // Model of the instruction sitting in WB.
  typedef struct packed {
    bit        v;
    bit        we;
    bit [4:0]  rd;
    bit [1:0]  sel;
    bit [2:0]  f3;
    bit [31:0] alu;
    bit [31:0] pc;
    bit [31:0] csr;
  } wb_m_t;

  wb_m_t     m;
  bit [63:0] m_cnt;

  function automatic bit [31:0] exp_wdata(wb_m_t s, bit [31:0] dmem);
    bit [31:0] b, h;
    b = (dmem >> (8 * s.alu[1:0])) & 32'hFF;
    h = (dmem >> (16 * s.alu[1])) & 32'hFFFF;
    case (s.sel)
      2'd0: return s.alu;
      2'd2: return s.pc + 32'd4;
      2'd3: return s.csr;
      default: begin
        case (s.f3)
          3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
          3'd4: return b;
          3'd1: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
          3'd5: return h;
          default: return dmem;
        endcase
      end
    endcase
  endfunction

  function automatic bit exp_we(wb_m_t s);
    return s.v && s.we && (s.rd != 5'd0);
  endfunction

  // Advance model from the inputs currently driven, then cross one edge.
  task automatic tick();
    if (rst_i) begin
      m = '0;
      m_cnt = '0;
    end else begin
      if (m.v && !stall_i) m_cnt = m_cnt + 64'd1;
      if (flush_i) m.v = 1'b0;
      else if (!stall_i)
        m = '{ex_valid_i, ex_reg_we_i, ex_rd_i, ex_wb_sel_i, ex_funct3_i,
              ex_alu_res_i, ex_pc_i, ex_csr_rdata_i};
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_ex(bit v, bit we, bit [4:0] rd, bit [1:0] sel, bit [2:0] f3,
                          bit [31:0] alu, bit [31:0] pc, bit [31:0] csr);
    ex_valid_i = v; ex_reg_we_i = we; ex_rd_i = rd; ex_wb_sel_i = sel;
    ex_funct3_i = f3; ex_alu_res_i = alu; ex_pc_i = pc; ex_csr_rdata_i = csr;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive_ex(1, 1, 5'd7, 2'd0, 3'd2, 32'hDEAD, 32'h0, 32'h0);
    dmem_rdata_i = 32'h0; raddr1_i = 5'd0; raddr2_i = 5'd5;
    rdata1_rf_i = 32'h11; rdata2_rf_i = 32'h22;
    tick(); tick();
    rst_i = 1'b0;
    drive_ex(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    #1;
    n_tests++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", we_o); end
    n_tests++; if (waddr_o !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", waddr_o); end
    n_tests++; if (wdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", wdata_o); end
    n_tests++; if (fwd_rdata1_o !== 32'h11) begin n_fail++; $display("FAIL reset_fwd1 got=%h exp=11", fwd_rdata1_o); end
    n_tests++; if (fwd_rdata2_o !== 32'h22) begin n_fail++; $display("FAIL reset_fwd2 got=%h exp=22", fwd_rdata2_o); end
`ifdef WB_INSTRET_EN
    n_tests++; if (instret_o !== 64'd0) begin n_fail++; $display("FAIL reset_instret got=%0d exp=0", instret_o); end
`endif
  endtask

  task automatic test_alu();
    drive_ex(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
    tick();
    drive_ex(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    n_tests++; if (we_o !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%b exp=1", we_o); end
    n_tests++; if (waddr_o !== 5'd5) begin n_fail++; $display("FAIL alu_waddr got=%0d exp=5", waddr_o); end
    n_tests++; if (wdata_o !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata got=%h exp=1234", wdata_o); end
    tick();
    n_tests++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL alu_bubble_we got=%b exp=0", we_o); end
  endtask

  task automatic test_loads();
    bit [2:0]  f3s  [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1};
    bit [1:0]  offs [6] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3};
    bit [31:0] exps [6] = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80F0,
                            32'h0000_7F81, 32'h80F0_7F81, 32'hFFFF_80F0};
    for (int i = 0; i < 6; i++) begin
      drive_ex(1, 1, 5'd1, 2'd1, f3s[i], {30'h400, offs[i]}, 32'h0, 32'h0);
      tick();
      dmem_rdata_i = 32'h80F0_7F81;
      #1;
      n_tests++;
      if (wdata_o !== exps[i]) begin
        n_fail++; $display("FAIL load_%0d f3=%0d off=%0d got=%h exp=%h", i, f3s[i], offs[i], wdata_o, exps[i]);
      end
    end
  endtask

  task automatic test_x0_bypass();
    drive_ex(1, 1, 5'd0, 2'd0, 3'd0, 32'd7, 32'h0, 32'h0);
    tick();
    raddr1_i = 5'd0; rdata1_rf_i = 32'hAAAA_0001; raddr2_i = 5'd0; rdata2_rf_i = 32'h0;
    #1;
    n_tests++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL x0_we got=%b exp=0", we_o); end
    n_tests++; if (fwd_rdata1_o !== 32'hAAAA_0001) begin n_fail++; $display("FAIL x0_fwd1 got=%h exp=aaaa0001", fwd_rdata1_o); end
    drive_ex(1, 1, 5'd3, 2'd0, 3'd0, 32'd19, 32'h0, 32'h0);
    tick();
    raddr2_i = 5'd3; rdata2_rf_i = 32'h0; raddr1_i = 5'd4; rdata1_rf_i = 32'h55;
    #1;
    n_tests++; if (fwd_rdata2_o !== 32'd19) begin n_fail++; $display("FAIL byp_fwd2 got=%h exp=13", fwd_rdata2_o); end
    n_tests++; if (fwd_rdata1_o !== 32'h55) begin n_fail++; $display("FAIL byp_fwd1 got=%h exp=55", fwd_rdata1_o); end
    // Load result must bypass in the same cycle.
    drive_ex(1, 1, 5'd4, 2'd1, 3'd0, 32'h1001, 32'h0, 32'h0);
    tick();
    dmem_rdata_i = 32'h0000_9900;
    #1;
    n_tests++; if (fwd_rdata1_o !== 32'hFFFF_FF99) begin n_fail++; $display("FAIL byp_load got=%h exp=ffffff99", fwd_rdata1_o); end
  endtask

  task automatic test_pc4_csr();
    drive_ex(1, 1, 5'd2, 2'd2, 3'd0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    tick();
    n_tests++; if (wdata_o !== 32'h0) begin n_fail++; $display("FAIL pc4_wrap got=%h exp=0", wdata_o); end
    drive_ex(1, 1, 5'd2, 2'd2, 3'd0, 32'h0, 32'h100, 32'h0);
    tick();
    n_tests++; if (wdata_o !== 32'h104) begin n_fail++; $display("FAIL pc4 got=%h exp=104", wdata_o); end
    drive_ex(1, 1, 5'd2, 2'd3, 3'd0, 32'h0, 32'h100, 32'hC5C5_0042);
    tick();
    n_tests++; if (wdata_o !== 32'hC5C5_0042) begin n_fail++; $display("FAIL csr got=%h exp=c5c50042", wdata_o); end
  endtask

  task automatic test_flush_stall();
    drive_ex(1, 1, 5'd7, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_tests++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL flush_we got=%b exp=0", we_o); end
    drive_ex(1, 1, 5'd9, 2'd0, 3'd0, 32'hABCD, 32'h0, 32'h0);
    tick();
    stall_i = 1'b1;
    drive_ex(1, 1, 5'd12, 2'd0, 3'd0, 32'h5555, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (we_o !== 1'b1 || waddr_o !== 5'd9 || wdata_o !== 32'hABCD) begin
        n_fail++; $display("FAIL stall_%0d got we=%b rd=%0d d=%h exp we=1 rd=9 d=abcd", i, we_o, waddr_o, wdata_o);
      end
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; stall_i = 1'b0;
    n_tests++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall_we got=%b exp=0", we_o); end
    drive_ex(1, 1, 5'd10, 2'd0, 3'd0, 32'h10, 32'h0, 32'h0);
    tick();
    rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    tick();
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    n_tests++; if (we_o !== 1'b0) begin n_fail++; $display("FAIL rst_prio_we got=%b exp=0", we_o); end
  endtask

  task automatic test_random();
    bit last_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst_i   = ($urandom_range(0, 99) < 3);
      stall_i = ($urandom_range(0, 99) < 20);
      flush_i = ($urandom_range(0, 99) < 10);
      drive_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
               2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
      tick();
      if (!last_stall || rst_i) dmem_rdata_i = $urandom;
      last_stall = stall_i;
      rst_i = 1'b0;
      raddr1_i = 5'($urandom_range(0, 7)); raddr2_i = 5'($urandom_range(0, 7));
      rdata1_rf_i = $urandom; rdata2_rf_i = $urandom;
      #1;
      n_tests++;
      if (we_o !== exp_we(m)) begin n_fail++; $display("FAIL rnd_we i=%0d got=%b exp=%b", i, we_o, exp_we(m)); end
      if (exp_we(m)) begin
        n_tests++;
        if (waddr_o !== m.rd || wdata_o !== exp_wdata(m, dmem_rdata_i)) begin
          n_fail++; $display("FAIL rnd_wr i=%0d got rd=%0d d=%h exp rd=%0d d=%h", i, waddr_o, wdata_o, m.rd, exp_wdata(m, dmem_rdata_i));
        end
      end
      n_tests++;
      if (fwd_rdata1_o !== ((exp_we(m) && raddr1_i == m.rd) ? exp_wdata(m, dmem_rdata_i) : rdata1_rf_i)) begin
        n_fail++; $display("FAIL rnd_fwd1 i=%0d got=%h", i, fwd_rdata1_o);
      end
      n_tests++;
      if (fwd_rdata2_o !== ((exp_we(m) && raddr2_i == m.rd) ? exp_wdata(m, dmem_rdata_i) : rdata2_rf_i)) begin
        n_fail++; $display("FAIL rnd_fwd2 i=%0d got=%h", i, fwd_rdata2_o);
      end
`ifdef WB_INSTRET_EN
      n_tests++;
      if (instret_o !== m_cnt) begin n_fail++; $display("FAIL rnd_instret i=%0d got=%0d exp=%0d", i, instret_o, m_cnt); end
`endif
    end
    stall_i = 1'b0; flush_i = 1'b0;
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_instret();
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive_ex(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick();
    rst_i = 1'b0;
    drive_ex(1, 1, 5'd1, 2'd0, 3'd0, 32'h1, 32'h0, 32'h0); tick();  // A enters
    flush_i = 1'b1;
    drive_ex(1, 1, 5'd2, 2'd0, 3'd0, 32'h2, 32'h0, 32'h0); tick();  // A retires, B killed
    flush_i = 1'b0;
    drive_ex(1, 1, 5'd3, 2'd0, 3'd0, 32'h3, 32'h0, 32'h0); tick();  // C enters
    stall_i = 1'b1; tick(); tick();                                  // C held 2 cycles
    stall_i = 1'b0;
    drive_ex(1, 1, 5'd4, 2'd0, 3'd0, 32'h4, 32'h0, 32'h0); tick();  // C retires, D enters
    drive_ex(0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0); tick();  // D retires
    tick();
    n_tests++; if (instret_o !== 64'd3) begin n_fail++; $display("FAIL instret got=%0d exp=3", instret_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_tests++; if (instret_o !== 64'd0) begin n_fail++; $display("FAIL instret_rst got=%0d exp=0", instret_o); end
  endtask
`endif

  initial begin
    m = '0;
    m_cnt = '0;
    test_reset();
    test_alu();
    test_loads();
    test_x0_bypass();
    test_pc4_csr();
    test_flush_stall();
    test_random();
`ifdef WB_INSTRET_EN
    test_instret();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
